// File: rtl/clk_rst_pkg.sv
// rtl/clk_rst_pkg.sv - shared types and helpers for clock/reset sequencing logic
package clk_rst_pkg;

   // Sequencer states, in the order a clean power-up walks through them
   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } seq_state_t;

   // Bits needed to hold any value in 0..max_value (never less than one bit)
   function automatic int cnt_width(input int max_value);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) <= max_value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/lock_reset_sequencer_if.sv
// rtl/lock_reset_sequencer_if.sv - control and status bundle of the lock qualifier / reset sequencer
interface lock_reset_sequencer_if #(
   parameter int NUM_CHANNELS = 4,
   parameter int CNT_WIDTH    = 8
);
   logic                    pll_locked;
   logic                    soft_reset;
   logic                    clear_loss;
   logic                    locked;
   logic [NUM_CHANNELS-1:0] chan_rst_n;
   logic                    all_ready;
   logic [CNT_WIDTH-1:0]    loss_count;

   // Side that owns the MMCM flag and the software controls
   modport master (
      output pll_locked, soft_reset, clear_loss,
      input  locked, chan_rst_n, all_ready, loss_count
   );

   // Sequencer side
   modport slave (
      input  pll_locked, soft_reset, clear_loss,
      output locked, chan_rst_n, all_ready, loss_count
   );
endinterface

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchroniser for a single asynchronous flag
module sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic reset_n,
   input  logic din,
   output logic dout
);
   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the raw flag through the chain; everything clears to 0 on reset
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign dout = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/lock_reset_sequencer.sv
// rtl/lock_reset_sequencer.sv - qualifies MMCM lock and releases domain resets in staggered order
module lock_reset_sequencer
   import clk_rst_pkg::*;
#(
   parameter int NUM_CHANNELS   = 4,
   parameter int LOCK_CYCLES    = 5,
   parameter int STAGGER_CYCLES = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int CNT_WIDTH      = 8
) (
   input logic                   clk_in,
   input logic                   reset_n,
   lock_reset_sequencer_if.slave bus
);
   localparam int STAB_W = cnt_width(LOCK_CYCLES);
   localparam int STAG_W = cnt_width(STAGGER_CYCLES);

   localparam logic [STAB_W-1:0]       STAB_LAST  = STAB_W'(LOCK_CYCLES - 1);
   localparam logic [STAG_W-1:0]       STAG_LAST  = STAG_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0]    LOSS_MAX   = '1;
   localparam logic [CNT_WIDTH-1:0]    LOSS_ONE   = CNT_WIDTH'(1);
   localparam logic [NUM_CHANNELS-1:0] CHAN_FIRST = NUM_CHANNELS'(1);

   seq_state_t              state_q, state_d;
   logic                    lock_s;
   logic [STAB_W-1:0]       stab_q, stab_d;
   logic [STAG_W-1:0]       stag_q, stag_d;
   logic                    locked_q, locked_d;
   logic [NUM_CHANNELS-1:0] chan_q, chan_d;
   logic [NUM_CHANNELS-1:0] chan_shift;
   logic                    ready_q, ready_d;
   logic [CNT_WIDTH-1:0]    loss_q, loss_d;
   logic                    qualify;
   logic                    stag_wrap;
   logic                    loss_evt;

   // pll_locked is only ever looked at through this synchroniser
   sync_bit #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .din     (bus.pll_locked),
      .dout    (lock_s)
   );

   // stab_q is 0 in WAIT_LOCK, so LOCK_CYCLES=1 qualifies straight from WAIT_LOCK
   assign qualify    = !bus.soft_reset && lock_s &&
                       ((state_q == WAIT_LOCK) || (state_q == STABLE)) &&
                       (stab_q == STAB_LAST);
   assign stag_wrap  = (stag_q == STAG_LAST);
   // Channels release strictly in order, so the next pattern is a shift-in of a 1
   assign chan_shift = (chan_q << 1) | CHAN_FIRST;
   // Drops during STABLE are glitches, not losses; soft_reset masks losses
   assign loss_evt   = !bus.soft_reset && !lock_s &&
                       ((state_q == RELEASE) || (state_q == RUN));

   // State register
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= WAIT_LOCK;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: soft_reset wins, then any lock drop restarts qualification
   always_comb begin
      state_d = state_q;
      if (bus.soft_reset) begin
         state_d = WAIT_LOCK;
      end else begin
         case (state_q)
            WAIT_LOCK, STABLE: begin
               if (!lock_s) begin
                  state_d = WAIT_LOCK;
               end else if (qualify) begin
                  state_d = (NUM_CHANNELS == 1) ? RUN : RELEASE;
               end else begin
                  state_d = STABLE;
               end
            end
            RELEASE: begin
               if (!lock_s) begin
                  state_d = WAIT_LOCK;
               end else if (stag_wrap && (&chan_shift)) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (!lock_s) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
         endcase
      end
   end

   // Next values of counters and registered outputs
   always_comb begin
      stab_d   = stab_q;
      stag_d   = stag_q;
      locked_d = locked_q;
      chan_d   = chan_q;
      ready_d  = ready_q;
      loss_d   = loss_q;

      if (bus.soft_reset || !lock_s) begin
         stab_d   = '0;
         stag_d   = '0;
         locked_d = 1'b0;
         chan_d   = '0;
         ready_d  = 1'b0;
      end else begin
         case (state_q)
            WAIT_LOCK, STABLE: begin
               if (qualify) begin
                  stab_d   = '0;
                  stag_d   = '0;
                  locked_d = 1'b1;
                  chan_d   = CHAN_FIRST;
                  ready_d  = (NUM_CHANNELS == 1);
               end else begin
                  stab_d = stab_q + 1'b1;
               end
            end
            RELEASE: begin
               if (stag_wrap) begin
                  stag_d  = '0;
                  chan_d  = chan_shift;
                  ready_d = &chan_shift;
               end else begin
                  stag_d = stag_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end

      // A loss on the same edge as a clear leaves exactly one recorded loss
      if (bus.clear_loss) loss_d = '0;
      if (loss_evt) begin
         if (bus.clear_loss) begin
            loss_d = LOSS_ONE;
         end else if (loss_q != LOSS_MAX) begin
            loss_d = loss_q + 1'b1;
         end
      end
   end

   // Counter and output registers
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         stab_q   <= '0;
         stag_q   <= '0;
         locked_q <= 1'b0;
         chan_q   <= '0;
         ready_q  <= 1'b0;
         loss_q   <= '0;
      end else begin
         stab_q   <= stab_d;
         stag_q   <= stag_d;
         locked_q <= locked_d;
         chan_q   <= chan_d;
         ready_q  <= ready_d;
         loss_q   <= loss_d;
      end
   end

   assign bus.locked     = locked_q;
   assign bus.chan_rst_n = chan_q;
   assign bus.all_ready  = ready_q;
   assign bus.loss_count = loss_q;
endmodule

// File: tb/tb_lock_reset_sequencer.sv
// tb/tb_lock_reset_sequencer.sv - directed self-checking bench for lock_reset_sequencer
module tb_lock_reset_sequencer;
   logic clk_in = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   lock_reset_sequencer_if #(.NUM_CHANNELS(4), .CNT_WIDTH(8)) bus_a ();
   lock_reset_sequencer_if #(.NUM_CHANNELS(1), .CNT_WIDTH(2)) bus_b ();

   lock_reset_sequencer #(
      .NUM_CHANNELS(4), .LOCK_CYCLES(5), .STAGGER_CYCLES(16), .SYNC_STAGES(2), .CNT_WIDTH(8)
   ) dut_a (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   lock_reset_sequencer #(
      .NUM_CHANNELS(1), .LOCK_CYCLES(5), .STAGGER_CYCLES(16), .SYNC_STAGES(2), .CNT_WIDTH(2)
   ) dut_b (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   always #5 clk_in = ~clk_in;

   // Advance one clock; cyc numbers the edge just taken, sampling 1 time unit later
   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) tick();
   endtask

   // Expected 4-channel pattern when bit 0 was released at edge base
   function automatic logic [3:0] exp_chan(input int base, input int c);
      int n;
      logic [4:0] ones;
      if (c < base) n = 0;
      else n = 1 + (c - base) / 16;
      if (n > 4) n = 4;
      ones = (5'd1 << n) - 5'd1;
      return ones[3:0];
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      bus_a.pll_locked = 1'b0; bus_a.soft_reset = 1'b0; bus_a.clear_loss = 1'b0;
      bus_b.pll_locked = 1'b0; bus_b.soft_reset = 1'b0; bus_b.clear_loss = 1'b0;
      repeat (3) tick();
      checks++; if (bus_a.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", bus_a.locked); end
      checks++; if (bus_a.chan_rst_n !== 4'b0000) begin errors++; $display("FAIL reset_chan got=%b exp=0000", bus_a.chan_rst_n); end
      checks++; if (bus_a.all_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus_a.all_ready); end
      checks++; if (bus_a.loss_count !== 8'd0) begin errors++; $display("FAIL reset_loss got=%0d exp=0", bus_a.loss_count); end
      checks++; if (bus_b.chan_rst_n !== 1'b0) begin errors++; $display("FAIL reset_b_chan got=%b exp=0", bus_b.chan_rst_n); end
      reset_n = 1'b1;
   endtask

   task automatic test_default_sequence();
      wait_to(10);
      bus_a.pll_locked = 1'b1;
      for (int c = 11; c <= 65; c++) begin
         tick();
         checks++; if (bus_a.locked !== (cyc >= 17)) begin errors++; $display("FAIL seq_locked cyc=%0d got=%b exp=%b", cyc, bus_a.locked, (cyc >= 17)); end
         checks++; if (bus_a.chan_rst_n !== exp_chan(17, cyc)) begin errors++; $display("FAIL seq_chan cyc=%0d got=%b exp=%b", cyc, bus_a.chan_rst_n, exp_chan(17, cyc)); end
         checks++; if (bus_a.all_ready !== (cyc >= 65)) begin errors++; $display("FAIL seq_ready cyc=%0d got=%b exp=%b", cyc, bus_a.all_ready, (cyc >= 65)); end
      end
   endtask

   task automatic test_loss_in_run();
      wait_to(70);
      bus_a.pll_locked = 1'b0;
      wait_to(72);
      checks++; if (bus_a.locked !== 1'b1) begin errors++; $display("FAIL loss_early got=%b exp=1", bus_a.locked); end
      tick();
      checks++; if (bus_a.locked !== 1'b0) begin errors++; $display("FAIL loss_locked got=%b exp=0", bus_a.locked); end
      checks++; if (bus_a.chan_rst_n !== 4'b0000) begin errors++; $display("FAIL loss_chan got=%b exp=0000", bus_a.chan_rst_n); end
      checks++; if (bus_a.all_ready !== 1'b0) begin errors++; $display("FAIL loss_ready got=%b exp=0", bus_a.all_ready); end
      checks++; if (bus_a.loss_count !== 8'd1) begin errors++; $display("FAIL loss_count got=%0d exp=1", bus_a.loss_count); end
      wait_to(75);
      bus_a.pll_locked = 1'b1;
      for (int c = 76; c <= 98; c++) begin
         tick();
         checks++; if (bus_a.chan_rst_n !== exp_chan(82, cyc)) begin errors++; $display("FAIL relock_chan cyc=%0d got=%b exp=%b", cyc, bus_a.chan_rst_n, exp_chan(82, cyc)); end
      end
   endtask

   task automatic test_soft_reset();
      wait_to(100);
      bus_a.soft_reset = 1'b1;
      tick();
      bus_a.soft_reset = 1'b0;
      checks++; if (bus_a.chan_rst_n !== 4'b0000) begin errors++; $display("FAIL soft_chan got=%b exp=0000", bus_a.chan_rst_n); end
      checks++; if (bus_a.locked !== 1'b0) begin errors++; $display("FAIL soft_locked got=%b exp=0", bus_a.locked); end
      checks++; if (bus_a.loss_count !== 8'd1) begin errors++; $display("FAIL soft_loss got=%0d exp=1", bus_a.loss_count); end
      for (int c = 102; c <= 106; c++) begin
         tick();
         checks++; if (bus_a.locked !== (cyc >= 106)) begin errors++; $display("FAIL soft_relock cyc=%0d got=%b exp=%b", cyc, bus_a.locked, (cyc >= 106)); end
      end
      checks++; if (bus_a.chan_rst_n !== 4'b0001) begin errors++; $display("FAIL soft_relock_chan got=%b exp=0001", bus_a.chan_rst_n); end
   endtask

   task automatic test_lock_glitch();
      wait_to(110);
      bus_a.soft_reset = 1'b1;
      bus_a.pll_locked = 1'b0;
      tick();
      checks++; if (bus_a.locked !== 1'b0) begin errors++; $display("FAIL hold_locked got=%b exp=0", bus_a.locked); end
      wait_to(115);
      bus_a.soft_reset = 1'b0;
      wait_to(120);
      bus_a.pll_locked = 1'b1;
      wait_to(123);
      bus_a.pll_locked = 1'b0;
      tick();
      bus_a.pll_locked = 1'b1;
      for (int c = 125; c <= 131; c++) begin
         tick();
         checks++; if (bus_a.locked !== (cyc >= 131)) begin errors++; $display("FAIL glitch_locked cyc=%0d got=%b exp=%b", cyc, bus_a.locked, (cyc >= 131)); end
         checks++; if (bus_a.loss_count !== 8'd1) begin errors++; $display("FAIL glitch_loss cyc=%0d got=%0d exp=1", cyc, bus_a.loss_count); end
      end
   endtask

   task automatic test_async_reset();
      wait_to(140);
      checks++; if (bus_a.chan_rst_n !== 4'b0001) begin errors++; $display("FAIL async_pre_chan got=%b exp=0001", bus_a.chan_rst_n); end
      #3;
      reset_n = 1'b0;
      #1;
      checks++; if (bus_a.locked !== 1'b0) begin errors++; $display("FAIL async_locked got=%b exp=0", bus_a.locked); end
      checks++; if (bus_a.chan_rst_n !== 4'b0000) begin errors++; $display("FAIL async_chan got=%b exp=0000", bus_a.chan_rst_n); end
      checks++; if (bus_a.loss_count !== 8'd0) begin errors++; $display("FAIL async_loss got=%0d exp=0", bus_a.loss_count); end
      bus_a.pll_locked = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_single_channel();
      wait_to(145);
      bus_b.pll_locked = 1'b1;
      for (int c = 146; c <= 152; c++) begin
         tick();
         checks++; if (bus_b.locked !== (cyc >= 152)) begin errors++; $display("FAIL one_locked cyc=%0d got=%b exp=%b", cyc, bus_b.locked, (cyc >= 152)); end
         checks++; if (bus_b.all_ready !== (cyc >= 152)) begin errors++; $display("FAIL one_ready cyc=%0d got=%b exp=%b", cyc, bus_b.all_ready, (cyc >= 152)); end
         checks++; if (bus_b.chan_rst_n !== (cyc >= 152)) begin errors++; $display("FAIL one_chan cyc=%0d got=%b exp=%b", cyc, bus_b.chan_rst_n, (cyc >= 152)); end
      end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_loss;
      for (int i = 1; i <= 5; i++) begin
         exp_loss = (i >= 3) ? 2'd3 : 2'(i);
         bus_b.pll_locked = 1'b0;
         repeat (3) tick();
         checks++; if (bus_b.loss_count !== exp_loss) begin errors++; $display("FAIL sat_loss i=%0d got=%0d exp=%0d", i, bus_b.loss_count, exp_loss); end
         checks++; if (bus_b.locked !== 1'b0) begin errors++; $display("FAIL sat_drop i=%0d got=%b exp=0", i, bus_b.locked); end
         bus_b.pll_locked = 1'b1;
         repeat (7) tick();
         checks++; if (bus_b.locked !== 1'b1) begin errors++; $display("FAIL sat_relock i=%0d got=%b exp=1", i, bus_b.locked); end
      end
      bus_b.pll_locked = 1'b0;
      repeat (2) tick();
      bus_b.clear_loss = 1'b1;
      tick();
      checks++; if (bus_b.loss_count !== 2'd1) begin errors++; $display("FAIL clear_with_loss got=%0d exp=1", bus_b.loss_count); end
      tick();
      bus_b.clear_loss = 1'b0;
      checks++; if (bus_b.loss_count !== 2'd0) begin errors++; $display("FAIL clear_alone got=%0d exp=0", bus_b.loss_count); end
   endtask

   initial begin
      test_reset();
      test_default_sequence();
      test_loss_in_run();
      test_soft_reset();
      test_lock_glitch();
      test_async_reset();
      test_single_channel();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
